fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Downstream consumer of the byte FIFO: pops 8-bit entries over the FIFO read port and
//  packs BYTES consecutive bytes into one wide word, presented on a valid/ready output.
//  Partial words are emitted early on flush, or on idle timeout when compiled in.
// PARAMETERS
//  DATA_W   8   width of one FIFO entry (rd_data)
//  BYTES    4   entries per output word; out_data width = DATA_W*BYTES
//  TIMEOUT  16  idle cycles before auto-flush (used only with PACKER_TIMEOUT_EN)
// PORTS
//  clk        in   1              single clock, all state on posedge
//  reset      in   1              asynchronous, active-low reset
//  rd_val     in   1              FIFO has data; rd_data valid while high (show-ahead)
//  rd_data    in   DATA_W         FIFO head entry
//  rd_en      out  1              pop request; entry consumed at posedge if rd_en&&rd_val
//  flush      in   1              emit the current partial word
//  out_valid  out  1              out_data/out_bytes hold a word
//  out_ready  in   1              consumer accepts word at posedge if out_valid&&out_ready
//  out_data   out  DATA_W*BYTES   packed word; first popped byte in bits [DATA_W-1:0]
//  out_bytes  out  $clog2(BYTES)+1  number of valid bytes in out_data (1..BYTES)
// BEHAVIOUR
//  - Reset (reset=0, async): state=COLLECT, cnt=0, out_valid=0, out_data=0, out_bytes=0;
//    rd_en forced 0 while reset is low.
//  - Pop = rd_en && rd_val. rd_en = rd_val && (state==COLLECT || out_ready) (combinational).
//  - COLLECT: each pop writes rd_data into lane cnt, cnt++. Pop with cnt==BYTES-1 ->
//    HOLD next cycle with out_valid=1, out_bytes=BYTES, cnt=0. Latency: out_valid high
//    the cycle after the last pop of the word.
//  - HOLD: out_data/out_bytes stable while out_valid&&!out_ready. On out_valid&&out_ready:
//    out_valid=0, state=COLLECT; a pop in that same cycle lands in lane 0 of the next word
//    (cnt=1), so back-to-back words sustain one pop per cycle.
//  - HOLD with out_ready=0: rd_en=0, no pops, FIFO backs up.
//  - flush in COLLECT with cnt>0: -> HOLD, out_bytes=cnt, unused lanes zero.
//    flush with cnt==0, or in HOLD: ignored (no empty words, no stored request).
//  - flush and pop same cycle: popped byte included first; out_bytes=cnt+1
//    (if that equals BYTES it is a normal full word).
//  - Unused lanes of out_data always zero; lanes cleared when a new word starts.
//  - cnt wraps BYTES-1 -> 0 only via word completion; never exceeds BYTES-1.
// CONFIGURATION
//  PACKER_TIMEOUT_EN defined: idle counter runs in COLLECT while cnt>0 and no pop; cleared
//    on pop, flush or leaving COLLECT. Reaching TIMEOUT-1 acts as flush (same rules as
//    flush), i.e. out_valid rises TIMEOUT cycles after the last pop.
//  Not defined: no idle counter, TIMEOUT ignored; partial words leave only via flush.
// TESTING
//  1 Push 0x11,0x22,0x33,0x44, out_ready=1 -> one word 0x44332211, out_bytes=4,
//    out_valid high exactly 1 cycle, the cycle after the 4th pop.
//  2 Push 8 bytes 0x01..0x08, out_ready=0 for 10 cycles, then 1 -> 0x04030201 held stable,
//    rd_en=0 during stall; then 0x08070605; no byte lost or duplicated.
//  3 Push 0xAA,0xBB, pulse flush -> out_data=0x0000BBAA, out_bytes=2; flush with cnt==0
//    -> no out_valid.
//  4 Pop 0xCC with flush same cycle after 0xAA,0xBB -> 0x00CCBBAA, out_bytes=3.
//  5 Push 0x11,0x22, assert reset=0 mid-word, release, push 0x55,0x66,0x77,0x88
//    -> out_valid=0 and out_data=0 during reset; single word 0x88776655.
//  6 PACKER_TIMEOUT_EN, TIMEOUT=8: push 0x01,0x02,0x03, idle -> out_valid rises 8 cycles
//    after last pop, 0x00030201, out_bytes=3; without macro no out_valid after 100 cycles.

Source files
------------

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a show-ahead FIFO read port and packs BYTES
// consecutive entries into one wide word on a valid/ready output. The first
// popped byte lands in the lowest lane. A partial word can be pushed out early
// with flush.
// Optional feature macro: PACKER_TIMEOUT_EN. When it is defined, a partial word
// that sits idle for TIMEOUT cycles is flushed automatically.
module fifo_word_packer #(
    parameter int DATA_W  = 8,
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_val,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      rd_en,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*BYTES-1:0]   out_data,
    output logic [$clog2(BYTES):0]    out_bytes
);

    localparam int CNT_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int BYTES_W = $clog2(BYTES) + 1;
    localparam int WORD_W  = DATA_W * BYTES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0]    data_q, data_d;
    logic [BYTES_W-1:0]   bytes_q, bytes_d;
    logic                 valid_q, valid_d;
    logic                 pop_s;
    logic                 flush_s;
    logic                 timeout_s;

    // Pop request: always accept in COLLECT; in HOLD only when the held word
    // leaves on this same edge. Held off entirely while reset is asserted.
    always_comb begin
        rd_en = reset & rd_val & ((state_q == ST_COLLECT) | out_ready);
    end

    assign pop_s   = rd_en;
    assign flush_s = flush | timeout_s;

`ifdef PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Idle counter: counts cycles a partial word waits without a pop. Firing at
    // TIMEOUT-2 means the counter would reach TIMEOUT-1 on this edge, so the
    // word becomes valid TIMEOUT cycles after the last pop.
    always_comb begin
        timeout_s = 1'b0;
        idle_d    = '0;
        if ((state_q == ST_COLLECT) && (cnt_q != '0) && !pop_s && !flush) begin
            if (idle_q == IDLE_W'(TIMEOUT - 2)) begin
                timeout_s = 1'b1;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic for lane filling, word completion, flush and hand-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        valid_d = valid_q;
        case (state_q)
            ST_COLLECT: begin
                if (pop_s) begin
                    if (cnt_q == '0) begin
                        // New word: clear every lane so unused lanes read zero.
                        data_d                = '0;
                        data_d[DATA_W-1:0]    = rd_data;
                    end else begin
                        data_d[int'(cnt_q)*DATA_W +: DATA_W] = rd_data;
                    end
                    if ((cnt_q == CNT_LAST) || flush_s) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                        bytes_d = BYTES_W'(cnt_q) + BYTES_W'(1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (flush_s && (cnt_q != '0)) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    bytes_d = BYTES_W'(cnt_q);
                    cnt_d   = '0;
                end else begin
                    // Nothing to do: keep collecting.
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_COLLECT;
                    valid_d = 1'b0;
                    bytes_d = '0;
                    data_d  = '0;
                    cnt_d   = '0;
                    if (pop_s) begin
                        // Byte popped during hand-off opens the next word.
                        data_d[DATA_W-1:0] = rd_data;
                        if (CNT_LAST == '0) begin
                            state_d = ST_HOLD;
                            valid_d = 1'b1;
                            bytes_d = BYTES_W'(1);
                        end else begin
                            cnt_d = CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    // Stalled: word stays stable, flush has no effect.
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
                data_d  = '0;
                bytes_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, lane counter and output word registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            data_q  <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_bytes = bytes_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: a FIFO model feeds bytes, expected words are
// queued when stimulus is driven and compared when the DUT hands a word off.
module tb_fifo_word_packer;

    localparam int DATA_W  = 8;
    localparam int BYTES   = 4;
    localparam int TIMEOUT = 8;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        rd_val    = 1'b0;
    logic [7:0]  rd_data   = 8'h00;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;
    logic        rd_en;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  nbytes;
    } word_t;

    logic [7:0] src_q [$];
    word_t      exp_q [$];

    int n_checks        = 0;
    int n_errors        = 0;
    int cyc             = 0;
    int last_pop_cyc    = -1;
    int first_valid_cyc = -1;
    int valid_cnt       = 0;

    fifo_word_packer #(
        .DATA_W (DATA_W),
        .BYTES  (BYTES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_val   (rd_val),
        .rd_data  (rd_data),
        .rd_en    (rd_en),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_bytes(out_bytes)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        rd_val  = (src_q.size() != 0);
        rd_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        src_q.push_back(b);
        drive_fifo();
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
        word_t w;
        w.data   = d;
        w.nbytes = n;
        exp_q.push_back(w);
    endtask

    task automatic start_test();
        valid_cnt       = 0;
        first_valid_cyc = -1;
    endtask

    // One clock cycle: sample at negedge, let the edge happen, update FIFO model.
    task automatic tick();
        logic  do_pop;
        word_t w;
        @(negedge clk);
        do_pop = rd_en && rd_val;
        if (out_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            check_eq("sb_word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check_eq("sb_data", 64'(out_data), 64'(w.data));
                check_eq("sb_bytes", 64'(out_bytes), 64'(w.nbytes));
            end
        end
        @(posedge clk);
        if (do_pop) last_pop_cyc = cyc;
        cyc++;
        #1;
        if (do_pop && (src_q.size() != 0)) void'(src_q.pop_front());
        drive_fifo();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (((exp_q.size() != 0) || (src_q.size() != 0)) && (k < 60)) begin
            tick();
            k++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with the FIFO claiming data to show rd_en is held off.
        #2;
        reset   = 1'b0;
        rd_val  = 1'b1;
        rd_data = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd_en", 64'(rd_en), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_bytes", 64'(out_bytes), 64'd0);
        drive_fifo();
        reset     = 1'b1;
        out_ready = 1'b1;

        // 1: one full word, valid exactly one cycle, the cycle after the last pop.
        start_test();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        expect_word(32'h44332211, 3'd4);
        drain("t1");
        repeat (3) tick();
        check_eq("t1_valid_cycles", 64'(valid_cnt), 64'd1);
        check_eq("t1_latency", 64'(first_valid_cyc - last_pop_cyc), 64'd1);

        // 2: two words with a 10-cycle consumer stall on the first.
        out_ready = 1'b0;
        start_test();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        begin
            int k;
            k = 0;
            while (!out_valid && (k < 20)) begin
                tick();
                k++;
            end
        end
        check_eq("t2_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t2_stall_valid", 64'(out_valid), 64'd1);
            check_eq("t2_stall_data", 64'(out_data), 64'h04030201);
            check_eq("t2_stall_bytes", 64'(out_bytes), 64'd4);
            check_eq("t2_stall_rd_en", 64'(rd_en), 64'd0);
        end
        check_eq("t2_fifo_backed_up", 64'(src_q.size()), 64'd4);
        out_ready = 1'b1;
        drain("t2");

        // 3: flush of a 2-byte partial word, then flush with nothing collected.
        start_test();
        push_byte(8'hAA); push_byte(8'hBB);
        tick(); tick();
        expect_word(32'h0000BBAA, 3'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("t3");
        repeat (2) tick();
        start_test();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        check_eq("t3_empty_flush_no_valid", 64'(valid_cnt), 64'd0);

        // 4: pop and flush in the same cycle.
        push_byte(8'hAA); push_byte(8'hBB);
        tick(); tick();
        push_byte(8'hCC);
        flush = 1'b1;
        expect_word(32'h00CCBBAA, 3'd3);
        tick();
        flush = 1'b0;
        drain("t4");

        // 5: reset mid-word discards the partial word.
        push_byte(8'h11); push_byte(8'h22);
        tick(); tick();
        reset = 1'b0;
        #1;
        check_eq("t5_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t5_rst_data", 64'(out_data), 64'd0);
        check_eq("t5_rst_bytes", 64'(out_bytes), 64'd0);
        push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
        #1;
        check_eq("t5_rst_rd_en", 64'(rd_en), 64'd0);
        repeat (3) begin
            tick();
            check_eq("t5_rst_hold_valid", 64'(out_valid), 64'd0);
            check_eq("t5_rst_hold_data", 64'(out_data), 64'd0);
        end
        reset = 1'b1;
        start_test();
        expect_word(32'h88776655, 3'd4);
        drain("t5");
        repeat (3) tick();
        check_eq("t5_valid_cycles", 64'(valid_cnt), 64'd1);

        // 6: idle partial word.
        start_test();
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
`ifdef PACKER_TIMEOUT_EN
        expect_word(32'h00030201, 3'd3);
        drain("t6");
        check_eq("t6_timeout_latency", 64'(first_valid_cyc - last_pop_cyc), 64'(TIMEOUT));
`else
        repeat (100) tick();
        check_eq("t6_no_auto_flush", 64'(valid_cnt), 64'd0);
        expect_word(32'h00030201, 3'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("t6");
`endif
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
